gru_cand_preact: RTL

- Computes the GRU candidate pre-activation th = sum(w[i]*x[i]) + bias over N_TERMS streamed operand pairs.
- Sits directly upstream of the tanh activation stage.
- Delivers th in sign-magnitude Q3.12: bit15 is the sign, bits14:0 are the magnitude, 0x1000 = 1.0.
- Launches the tanh stage with cs_tanh, holds th stable while tanh computes, and reports completion once tanh signals ready.

---
 rtl/gru_cand_preact.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gru_cand_preact.sv
// -----------------------------------------------------------------------------
// gru_cand_preact
//
// Purpose:
//   Computes the GRU candidate pre-activation th = sum(w[i]*x[i]) + bias over
//   N_TERMS streamed sign-magnitude Q3.12 operand pairs. It then hands th to
//   the downstream tanh stage. The block launches tanh with a one-cycle
//   cs_tanh strobe and holds th stable while tanh works. It pulses done once
//   tanh has gone busy and then returned to ready.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   start     in   begin a new pre-activation (sampled only when idle)
//   bias      in   sign-magnitude Q3.12 bias, latched on accepted start
//   in_valid  in   w_in/x_in carry a valid pair this cycle
//   in_ready  out  block accepts a pair this cycle
//   w_in      in   weight, sign-magnitude Q3.12
//   x_in      in   input/hidden element, sign-magnitude Q3.12
//   th        out  pre-activation to tanh, sign-magnitude Q3.12
//   cs_tanh   out  one-cycle launch strobe to the tanh stage
//   rdy_t     in   tanh ready: high when idle/done, low while busy
//   busy      out  high whenever the block is not idle
//   done      out  one-cycle pulse once tanh has finished with th
// -----------------------------------------------------------------------------
module gru_cand_preact #(
  parameter int N_TERMS = 8,
  parameter int DW      = 16,
  parameter int FRAC    = 12,
  parameter int ACC_W   = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] bias,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] w_in,
  input  logic [DW-1:0] x_in,
  output logic [DW-1:0] th,
  output logic          cs_tanh,
  input  logic          rdy_t,
  output logic          busy,
  output logic          done
);

  // Magnitude width of one operand and of one full-precision product.
  localparam int MW    = DW - 1;
  localparam int PW    = 2 * MW;
  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_NORM,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [DW-1:0]      r_th;

  logic [PW-1:0]      w_prod_mag;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_prod_term;
  logic [ACC_W-1:0]   w_bias_ext;
  logic [ACC_W-1:0]   w_bias_term;
  logic [ACC_W-1:0]   w_abs;
  logic [ACC_W-1:0]   w_shift;
  logic [MW-1:0]      w_mag;
  logic [DW-1:0]      w_th_next;

  // Sign-magnitude operands are converted to two's complement before they
  // reach the accumulator. Both the product and the bias are aligned to
  // 2*FRAC fractional bits. A negative-zero operand therefore adds nothing.
  assign w_prod_mag  = PW'(w_in[MW-1:0]) * PW'(x_in[MW-1:0]);
  assign w_prod_ext  = ACC_W'(w_prod_mag);
  assign w_prod_term = (w_in[DW-1] ^ x_in[DW-1]) ? (~w_prod_ext + 1'b1) : w_prod_ext;
  assign w_bias_ext  = ACC_W'(bias[MW-1:0]) << FRAC;
  assign w_bias_term = bias[DW-1] ? (~w_bias_ext + 1'b1) : w_bias_ext;

  // Normalisation works on the absolute value, so the right shift truncates
  // toward zero for both signs. An oversized result saturates the magnitude.
  // A zero magnitude is forced to +0 so the tanh stage never sees 0x8000.
  assign w_abs     = r_acc[ACC_W-1] ? (~r_acc + 1'b1) : r_acc;
  assign w_shift   = w_abs >> FRAC;
  assign w_mag     = (w_shift > ACC_W'({MW{1'b1}})) ? {MW{1'b1}} : w_shift[MW-1:0];
  assign w_th_next = (w_mag == '0) ? '0 : {r_acc[ACC_W-1], w_mag};

  assign th = r_th;

  // State register plus datapath registers. A reset clears everything
  // immediately and abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_th    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= w_bias_term;
            r_cnt <= '0;
          end
        end
        S_MAC: begin
          if (in_valid) begin
            r_acc <= r_acc + w_prod_term;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_NORM: begin
          r_th <= w_th_next;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode. done is taken from rdy_t in WAIT_HI so that
  // it fires in the same cycle as the return to idle. It therefore can never
  // coincide with cs_tanh, which is raised only in ISSUE.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    cs_tanh  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_MAC;
      end
      S_MAC: begin
        in_ready = 1'b1;
        if (in_valid && (r_cnt == LAST)) w_next = S_NORM;
      end
      S_NORM: begin
        w_next = S_ISSUE;
      end
      S_ISSUE: begin
        cs_tanh = 1'b1;
        w_next  = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!rdy_t) w_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (rdy_t) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
